// File: rtl/simple_spi_slave.sv
// simple_spi_slave: SPI target that oversamples the SPI pins on system_clk.
// Received words are presented on data_rx, and each word to send is fetched
// from data_tx. Both hand-offs are marked with single-cycle strobes.
// All four CPOL/CPHA modes and both bit orders are supported.
// Ports:
//   system_clk, rst            - system clock, synchronous active-high reset
//   cpol, cpha, msb_first      - mode configuration, latched at CS assert
//   data_tx / xfer_word_load   - next word to send / capture strobe
//   data_rx / xfer_word_completed - last received word / update strobe
//   xfer_active, spi_miso_oe   - slave is in SHIFT with CS asserted
//   spi_cs, spi_clk, spi_mosi  - SPI pins from the master (async)
//   spi_miso                   - SPI data to the master
module simple_spi_slave #(
  parameter int unsigned WORDWIDTH   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 system_clk,
  input  logic                 rst,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 msb_first,
  input  logic [WORDWIDTH-1:0] data_tx,
  output logic                 xfer_word_load,
  output logic [WORDWIDTH-1:0] data_rx,
  output logic                 xfer_word_completed,
  output logic                 xfer_active,
  input  logic                 spi_cs,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe
);

  localparam int unsigned CNT_W = (WORDWIDTH > 2) ? $clog2(WORDWIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORDWIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Input synchronizers plus one delay flop for edge detection
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES:0]   valid_q;
  logic                   cs_dly_q;
  logic                   sclk_dly_q;
  logic                   mosi_dly_q;
  logic                   cs_rise_q;
  logic                   cs_fall_q;
  logic                   sclk_rise_q;
  logic                   sclk_fall_q;

  logic cs_s;
  logic sclk_s;
  logic edge_ok;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  // Edges are trusted only once the whole chain holds post-reset samples, so a
  // CS held high through reset is never mistaken for a fresh assertion.
  assign edge_ok = valid_q[SYNC_STAGES];

  // Synchronizer and registered edge detectors
  always_ff @(posedge system_clk) begin
    if (rst) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      valid_q     <= '0;
      cs_dly_q    <= 1'b0;
      sclk_dly_q  <= 1'b0;
      mosi_dly_q  <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      valid_q     <= {valid_q[SYNC_STAGES-1:0], 1'b1};
      cs_dly_q    <= cs_s;
      sclk_dly_q  <= sclk_s;
      // MOSI delayed by one so it lines up with the registered edge strobes
      mosi_dly_q  <= mosi_sync_q[SYNC_STAGES-1];
      cs_rise_q   <= edge_ok &  cs_s   & ~cs_dly_q;
      cs_fall_q   <= edge_ok & ~cs_s   &  cs_dly_q;
      sclk_rise_q <= edge_ok &  sclk_s & ~sclk_dly_q;
      sclk_fall_q <= edge_ok & ~sclk_s &  sclk_dly_q;
    end
  end

  // Transfer state
  logic [0:0]           state_q, state_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic                 msb_q, msb_d;
  logic [WORDWIDTH-1:0] tx_q, tx_d;
  logic [WORDWIDTH-1:0] rx_q, rx_d;
  logic [WORDWIDTH-1:0] data_rx_q, data_rx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 miso_q, miso_d;
  logic                 load_q, load_d;
  logic                 done_q, done_d;

  // Mode-dependent edge roles and shift helpers
  logic                 lead_edge;
  logic                 trail_edge;
  logic                 sample_edge;
  logic                 drive_edge;
  logic                 tx_bit;
  logic [WORDWIDTH-1:0] tx_shifted;
  logic [WORDWIDTH-1:0] rx_next;
  logic                 first_bit_in;
  logic [WORDWIDTH-1:0] first_shift_in;

  always_comb begin
    lead_edge      = cpol_q ? sclk_fall_q : sclk_rise_q;
    trail_edge     = cpol_q ? sclk_rise_q : sclk_fall_q;
    sample_edge    = cpha_q ? trail_edge : lead_edge;
    drive_edge     = cpha_q ? lead_edge : trail_edge;
    tx_bit         = msb_q ? tx_q[WORDWIDTH-1] : tx_q[0];
    tx_shifted     = msb_q ? {tx_q[WORDWIDTH-2:0], 1'b0} : {1'b0, tx_q[WORDWIDTH-1:1]};
    rx_next        = msb_q ? {rx_q[WORDWIDTH-2:0], mosi_dly_q} : {mosi_dly_q, rx_q[WORDWIDTH-1:1]};
    // At CS assert the config inputs are used directly since they are being latched
    first_bit_in   = msb_first ? data_tx[WORDWIDTH-1] : data_tx[0];
    first_shift_in = msb_first ? {data_tx[WORDWIDTH-2:0], 1'b0} : {1'b0, data_tx[WORDWIDTH-1:1]};
  end

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    msb_d     = msb_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rx_d = data_rx_q;
    cnt_d     = cnt_q;
    miso_d    = miso_q;
    load_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_rise_q) begin
          state_d = ST_SHIFT;
          cpol_d  = cpol;
          cpha_d  = cpha;
          msb_d   = msb_first;
          load_d  = 1'b1;
          cnt_d   = '0;
          rx_d    = '0;
          if (!cpha) begin
            // cpha=0: first bit must be on the pin before the first lead edge
            miso_d = first_bit_in;
            tx_d   = first_shift_in;
          end else begin
            tx_d   = data_tx;
          end
        end
      end
      ST_SHIFT: begin
        if (cs_fall_q) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end else if (sample_edge) begin
          rx_d = rx_next;
          if (cnt_q == LAST_BIT) begin
            // Word complete: publish it and prefetch the next tx word unshifted,
            // its first bit goes out on the following drive edge
            data_rx_d = rx_next;
            done_d    = 1'b1;
            load_d    = 1'b1;
            tx_d      = data_tx;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (drive_edge) begin
          miso_d = tx_bit;
          tx_d   = tx_shifted;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge system_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      msb_q     <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
      cnt_q     <= '0;
      miso_q    <= 1'b0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      msb_q     <= msb_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
      cnt_q     <= cnt_d;
      miso_q    <= miso_d;
      load_q    <= load_d;
      done_q    <= done_d;
    end
  end

  assign xfer_word_load      = load_q;
  assign xfer_word_completed = done_q;
  assign data_rx             = data_rx_q;
  assign spi_miso            = miso_q;
  assign xfer_active         = (state_q == ST_SHIFT);
  assign spi_miso_oe         = (state_q == ST_SHIFT);

endmodule
